// File: rtl/pattern_compare_if.sv
// Bus bundle between the pattern-match FSM, the compare stage
// and the pattern memory.
interface pattern_compare_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) ();
  logic                  inc_flag;
  logic                  load_pattern;
  logic [DATA_WIDTH-1:0] pattern_in;
  logic [DATA_WIDTH-1:0] mask_in;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] match_address;
  logic                  match_found;
  logic                  done_flag;

  modport master (
    output inc_flag, load_pattern, pattern_in, mask_in, mem_data,
    input  mem_addr, mem_rd, match_address, match_found, done_flag
  );

  modport slave (
    input  inc_flag, load_pattern, pattern_in, mask_in, mem_data,
    output mem_addr, mem_rd, match_address, match_found, done_flag
  );
endinterface

// File: rtl/pattern_compare.sv
// Masked pattern scan over the pattern memory; reports the first
// matching address and a done flag to the pattern-match FSM.
module pattern_compare #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 512
) (
  input  logic               clock,
  input  logic               reset,
  pattern_compare_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic                  res_hit_q, res_hit_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
  logic                  match_found_q, match_found_d;
  logic                  done_q, done_d;

  logic hit;
  logic last;

  assign hit  = ((bus.mem_data ^ pat_q) & mask_q) == '0;
  assign last = addr_q == LAST;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      pat_q         <= '0;
      mask_q        <= '0;
      res_addr_q    <= '0;
      res_hit_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      match_addr_q  <= '0;
      match_found_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pat_q         <= pat_d;
      mask_q        <= mask_d;
      res_addr_q    <= res_addr_d;
      res_hit_q     <= res_hit_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      match_addr_q  <= match_addr_d;
      match_found_q <= match_found_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pat_d      = pat_q;
    mask_d     = mask_q;
    res_addr_d = res_addr_q;
    res_hit_d  = res_hit_q;
    if (bus.load_pattern &&
        (state_q == IDLE || state_q == DONE)) begin
      pat_d  = bus.pattern_in;
      mask_d = bus.mask_in;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.inc_flag) begin
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        unique case (1'b1)
          !bus.inc_flag: state_d = IDLE;
          hit || last: begin
            res_addr_d = addr_q;
            res_hit_d  = hit;
            state_d    = DONE;
          end
          default: begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = READ;
          end
        endcase
      end
      DONE: begin
        if (!bus.inc_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results publish one edge after entering DONE; done then
  // drops on the first edge that sees inc_flag low.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = state_q == READ;
    match_addr_d  = match_addr_q;
    match_found_d = match_found_q;
    done_d        = (state_q == DONE) &&
                    (bus.inc_flag || !done_q);
    unique case (state_q)
      IDLE: begin
        if (bus.inc_flag) begin
          match_addr_d  = '0;
          match_found_d = 1'b0;
        end
      end
      READ: mem_addr_d = addr_q;
      DONE: begin
        if (!done_q) begin
          match_addr_d  = res_addr_q;
          match_found_d = res_hit_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.match_address = match_addr_q;
  assign bus.match_found   = match_found_q;
  assign bus.done_flag     = done_q;
endmodule

// File: tb/tb_pattern_compare.sv
// Scoreboard bench for pattern_compare: a reference scan of the
// memory image predicts address, hit flag and done latency.
module tb_pattern_compare;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int DEPTH = 512;

  typedef struct {
    logic [AW-1:0] addr;
    logic          found;
    int            lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pattern_compare_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pattern_compare #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          tog_en = 1'b0;
  logic [DW-1:0] tog_val = '0;
  assign bus.mem_data = tog_en ? tog_val : mem[bus.mem_addr];

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  int rd_cnt = 0;
  int rd_next = 0;
  int rd_bad = 0;
  int rd_first = -1;

  always @(negedge clock) begin
    if (bus.mem_rd) begin
      if (rd_first < 0) rd_first = int'(bus.mem_addr);
      if (int'(bus.mem_addr) != rd_next) rd_bad++;
      rd_next++;
      rd_cnt++;
    end
  end

  task automatic rd_clear();
    rd_cnt = 0; rd_next = 0; rd_bad = 0; rd_first = -1;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int a = 0; a < DEPTH; a++) mem[a] = v;
  endtask

  function automatic exp_t model(input logic [DW-1:0] p,
                                 input logic [DW-1:0] m);
    exp_t e;
    e.addr = AW'(DEPTH - 1);
    e.found = 1'b0;
    e.lat = 2 * DEPTH + 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (((mem[a] ^ p) & m) == '0) begin
        e.addr = AW'(a);
        e.found = 1'b1;
        e.lat = 2 * a + 3;
        return e;
      end
    end
    return e;
  endfunction

  // Returns at the negedge after the start edge.
  task automatic start(input logic [DW-1:0] p,
                       input logic [DW-1:0] m);
    @(negedge clock);
    bus.pattern_in = p;
    bus.mask_in = m;
    bus.load_pattern = 1'b1;
    bus.inc_flag = 1'b1;
    sb.push_back(model(p, m));
    @(negedge clock);
    bus.load_pattern = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    int n;
    n = 1;
    to = 1'b1;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      n++;
      #1;
      if (bus.done_flag) begin
        to = 1'b0;
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic wait_addr(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (int'(bus.mem_addr) == a && bus.mem_rd) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inc_flag = 1'b1;
    tog_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tog_val = ~tog_val;
    end
    n_cmp++;
    if ({bus.done_flag, bus.match_found, bus.mem_rd} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000",
               {bus.done_flag, bus.match_found, bus.mem_rd});
    end
    n_cmp++;
    if (bus.mem_addr !== '0 || bus.match_address !== '0) begin
      n_err++;
      $display("FAIL reset_addr got %0d/%0d want 0/0",
               bus.mem_addr, bus.match_address);
    end
    bus.inc_flag = 1'b0;
    tog_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_match();
    exp_t e;
    int lat;
    bit to;
    fill(8'h00);
    mem[37] = 8'hA5;
    start(8'hA5, 8'hFF);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || lat != 77) begin
      n_err++;
      $display("FAIL basic_latency got %0d want %0d", lat, e.lat);
    end
    n_cmp++;
    if (bus.match_found !== e.found || bus.match_address !== e.addr) begin
      n_err++;
      $display("FAIL basic_result got %b/%0d want %b/%0d",
               bus.match_found, bus.match_address, e.found, e.addr);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.done_flag !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_drop got %b want 0", bus.done_flag);
    end
    n_cmp++;
    if (bus.match_found !== 1'b1 || bus.match_address !== 9'd37) begin
      n_err++;
      $display("FAIL basic_hold got %b/%0d want 1/37",
               bus.match_found, bus.match_address);
    end
    @(negedge clock);
  endtask

  task automatic test_masked();
    exp_t e;
    int lat;
    bit to;
    fill(8'h00);
    mem[0] = 8'hF3;
    start(8'hF0, 8'hF0);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || bus.match_address !== e.addr ||
        bus.match_found !== e.found) begin
      n_err++;
      $display("FAIL masked got lat %0d addr %0d f %b want %0d %0d %b",
               lat, bus.match_address, bus.match_found,
               e.lat, e.addr, e.found);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(negedge clock);
    // Zero mask matches the first word whatever it holds.
    fill(8'h3C);
    start(8'h00, 8'h00);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || bus.match_address !== e.addr ||
        bus.match_found !== 1'b1) begin
      n_err++;
      $display("FAIL zero_mask got lat %0d addr %0d want %0d %0d",
               lat, bus.match_address, e.lat, e.addr);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_no_match();
    exp_t e;
    int lat;
    bit to;
    fill(8'h00);
    rd_clear();
    start(8'hFF, 8'hFF);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || lat != 1025) begin
      n_err++;
      $display("FAIL nomatch_latency got %0d want %0d", lat, e.lat);
    end
    n_cmp++;
    if (bus.match_found !== 1'b0 || bus.match_address !== 9'h1FF) begin
      n_err++;
      $display("FAIL nomatch_result got %b/%h want 0/1ff",
               bus.match_found, bus.match_address);
    end
    @(negedge clock);
    n_cmp++;
    if (rd_cnt != DEPTH || rd_bad != 0) begin
      n_err++;
      $display("FAIL nomatch_sweep got %0d reads %0d bad want 512/0",
               rd_cnt, rd_bad);
    end
    bus.inc_flag = 1'b0;
    @(negedge clock);
    mem[DEPTH-1] = 8'h5A;
    start(8'h5A, 8'hFF);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || lat != e.lat || bus.match_found !== 1'b1 ||
        bus.match_address !== 9'h1FF) begin
      n_err++;
      $display("FAIL last_hit got lat %0d f %b addr %h want %0d 1 1ff",
               lat, bus.match_found, bus.match_address, e.lat);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_abort();
    exp_t e;
    int lat;
    int seen;
    bit to;
    bit ok;
    fill(8'h00);
    start(8'h77, 8'hFF);
    wait_addr(100, ok);
    bus.inc_flag = 1'b0;
    void'(sb.pop_front());
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done_flag || bus.mem_rd) seen++;
    end
    n_cmp++;
    if (!ok || seen != 0) begin
      n_err++;
      $display("FAIL abort_quiet got reach %b active %0d want 1/0",
               ok, seen);
    end
    n_cmp++;
    if (bus.match_found !== 1'b0 || bus.match_address !== '0) begin
      n_err++;
      $display("FAIL abort_cleared got %b/%0d want 0/0",
               bus.match_found, bus.match_address);
    end
    mem[12] = 8'h77;
    rd_clear();
    start(8'h77, 8'hFF);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || rd_first != 0 || lat != e.lat ||
        bus.match_address !== e.addr) begin
      n_err++;
      $display("FAIL abort_restart got first %0d lat %0d addr %0d want 0 %0d %0d",
               rd_first, lat, bus.match_address, e.lat, e.addr);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_done_hold();
    exp_t e;
    int lat;
    int bad;
    bit to;
    bit ok;
    fill(8'h00);
    mem[5] = 8'h42;
    start(8'h42, 8'hFF);
    wait_done(lat, to);
    e = sb.pop_front();
    rd_clear();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done_flag !== 1'b1 || bus.mem_rd !== 1'b0 ||
          bus.match_address !== e.addr) bad++;
    end
    n_cmp++;
    if (to || bad != 0 || rd_cnt != 0) begin
      n_err++;
      $display("FAIL done_hold got bad %0d reads %0d want 0/0",
               bad, rd_cnt);
    end
    bus.inc_flag = 1'b0;
    @(negedge clock);
    @(negedge clock);
    fill(8'h00);
    mem[10] = 8'h99;
    mem[300] = 8'h66;
    start(8'h66, 8'hFF);
    wait_addr(5, ok);
    bus.pattern_in = 8'h99;
    bus.load_pattern = 1'b1;
    @(negedge clock);
    bus.load_pattern = 1'b0;
    @(negedge clock);
    bus.load_pattern = 1'b1;
    @(negedge clock);
    bus.load_pattern = 1'b0;
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || to || bus.match_address !== e.addr ||
        bus.match_found !== 1'b1) begin
      n_err++;
      $display("FAIL load_in_scan got %0d/%b want %0d/1",
               bus.match_address, bus.match_found, e.addr);
    end
    @(negedge clock);
    bus.inc_flag = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    bit ok;
    fill(8'h00);
    start(8'hEE, 8'hFF);
    wait_addr(200, ok);
    void'(sb.pop_front());
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (!ok || bus.mem_addr !== '0 || bus.mem_rd !== 1'b0 ||
        bus.done_flag !== 1'b0 || bus.match_found !== 1'b0 ||
        bus.match_address !== '0) begin
      n_err++;
      $display("FAIL async_reset got addr %0d rd %b done %b want 0 0 0",
               bus.mem_addr, bus.mem_rd, bus.done_flag);
    end
    bus.inc_flag = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    bus.inc_flag = 1'b0;
    bus.load_pattern = 1'b0;
    bus.pattern_in = '0;
    bus.mask_in = '0;
    fill(8'h00);
    test_reset();
    test_basic_match();
    test_masked();
    test_no_match();
    test_abort();
    test_done_hold();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
